// File: rtl/pic_bus_controller.sv
// Bus-side sequencer for the 8259-style PIC: strobe sampling, ICW1-4 init,
// OCW1/OCW3 state, read-data mux, INTA sequencing and buffer enable/direction.
module pic_bus_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic       inta_n,
  input  logic [7:0] wdata,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic [2:0] vec_id,
  output logic [7:0] rd_data,
  output logic       bus_en,
  output logic       bus_ino,
  output logic [7:0] imr,
  output logic [4:0] vec_base,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [7:0] icw3,
  output logic       aeoi,
  output logic       sfnm,
  output logic       ocw2_stb,
  output logic [7:0] ocw2_data,
  output logic       ack1,
  output logic       ack2,
  output logic       init_done
);

  typedef enum logic [2:0] {
    S_UNINIT,
    S_WAIT_ICW2,
    S_WAIT_ICW3,
    S_WAIT_ICW4,
    S_READY
  } init_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ACK1,
    A_ACK2
  } inta_state_t;

  logic        r_cs_q;
  logic        r_rd_q;
  logic        r_wr_q;
  logic        r_a0_q;
  logic        r_inta_q;
  logic        r_inta_qq;
  logic [7:0]  r_wdata_q;

  logic        r_cmt;
  logic        r_cmt_a0;
  logic [7:0]  r_cmt_data;

  init_state_t r_state;
  inta_state_t r_inta_state;

  logic [7:0]  r_rd_data;
  logic        r_bus_en;
  logic        r_bus_ino;
  logic [7:0]  r_imr;
  logic [4:0]  r_vec_base;
  logic        r_ltim;
  logic        r_sngl;
  logic        r_ic4;
  logic [7:0]  r_icw3;
  logic        r_aeoi;
  logic        r_sfnm;
  logic        r_ocw2_stb;
  logic [7:0]  r_ocw2_data;
  logic        r_ack1;
  logic        r_ack2;
  logic        r_init_done;
  logic        r_rsel_isr;

  logic        w_wr_commit;
  logic        w_inta_fall;
  logic        w_vec_drive;
  logic        w_wr_drive;
  logic        w_rd_drive;

  // Strobes reset to their idle (high) level so release from reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_q    <= 1'b1;
      r_rd_q    <= 1'b1;
      r_wr_q    <= 1'b1;
      r_a0_q    <= 1'b0;
      r_inta_q  <= 1'b1;
      r_inta_qq <= 1'b1;
      r_wdata_q <= 8'h00;
    end else begin
      r_cs_q    <= cs_n;
      r_rd_q    <= rd_n;
      r_wr_q    <= wr_n;
      r_a0_q    <= a0;
      r_inta_q  <= inta_n;
      r_inta_qq <= r_inta_q;
      r_wdata_q <= wdata;
    end
  end

  assign w_wr_commit = ~r_wr_q & wr_n & ~r_cs_q;
  assign w_inta_fall = r_inta_qq & ~r_inta_q;
  assign w_vec_drive = ((r_inta_state == A_ACK1) && w_inta_fall) ||
                       ((r_inta_state == A_ACK2) && !r_inta_q);
  assign w_wr_drive  = ~r_cs_q & ~r_wr_q;
  assign w_rd_drive  = ~r_cs_q & ~r_rd_q & r_inta_q & r_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmt      <= 1'b0;
      r_cmt_a0   <= 1'b0;
      r_cmt_data <= 8'h00;
    end else begin
      r_cmt      <= w_wr_commit;
      r_cmt_a0   <= r_a0_q;
      r_cmt_data <= r_wdata_q;
    end
  end

  // ICW1 restarts initialisation from any state; everything else depends on where we are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_UNINIT;
      r_imr       <= 8'h00;
      r_vec_base  <= 5'h00;
      r_ltim      <= 1'b0;
      r_sngl      <= 1'b0;
      r_ic4       <= 1'b0;
      r_icw3      <= 8'h00;
      r_aeoi      <= 1'b0;
      r_sfnm      <= 1'b0;
      r_ocw2_stb  <= 1'b0;
      r_ocw2_data <= 8'h00;
      r_init_done <= 1'b0;
      r_rsel_isr  <= 1'b0;
    end else begin
      r_ocw2_stb <= 1'b0;
      if (r_cmt) begin
        if (!r_cmt_a0 && r_cmt_data[4]) begin
          r_ltim      <= r_cmt_data[3];
          r_sngl      <= r_cmt_data[1];
          r_ic4       <= r_cmt_data[0];
          r_imr       <= 8'h00;
          r_icw3      <= 8'h00;
          r_aeoi      <= 1'b0;
          r_sfnm      <= 1'b0;
          r_init_done <= 1'b0;
          r_rsel_isr  <= 1'b0;
          r_state     <= S_WAIT_ICW2;
        end else begin
          case (r_state)
            S_WAIT_ICW2: if (r_cmt_a0) begin
              r_vec_base <= r_cmt_data[7:3];
              if (!r_sngl) begin
                r_state <= S_WAIT_ICW3;
              end else if (r_ic4) begin
                r_state <= S_WAIT_ICW4;
              end else begin
                r_state     <= S_READY;
                r_init_done <= 1'b1;
              end
            end
            S_WAIT_ICW3: if (r_cmt_a0) begin
              r_icw3 <= r_cmt_data;
              if (r_ic4) begin
                r_state <= S_WAIT_ICW4;
              end else begin
                r_state     <= S_READY;
                r_init_done <= 1'b1;
              end
            end
            S_WAIT_ICW4: if (r_cmt_a0) begin
              r_aeoi      <= r_cmt_data[1];
              r_sfnm      <= r_cmt_data[4];
              r_state     <= S_READY;
              r_init_done <= 1'b1;
            end
            S_READY: begin
              if (r_cmt_a0) begin
                r_imr <= r_cmt_data;
              end else if (!r_cmt_data[3]) begin
                r_ocw2_stb  <= 1'b1;
                r_ocw2_data <= r_cmt_data;
              end else if (r_cmt_data[1]) begin
                r_rsel_isr <= r_cmt_data[0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inta_state <= A_IDLE;
      r_ack1       <= 1'b0;
      r_ack2       <= 1'b0;
    end else begin
      r_ack1 <= 1'b0;
      r_ack2 <= 1'b0;
      case (r_inta_state)
        A_IDLE: if (w_inta_fall) begin
          r_inta_state <= A_ACK1;
          r_ack1       <= 1'b1;
        end
        A_ACK1: if (w_inta_fall) begin
          r_inta_state <= A_ACK2;
          r_ack2       <= 1'b1;
        end
        A_ACK2: if (r_inta_q) begin
          r_inta_state <= A_IDLE;
        end
        default: r_inta_state <= A_IDLE;
      endcase
    end
  end

  // Vector drive beats a CPU write, and a write beats a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_en  <= 1'b0;
      r_bus_ino <= 1'b0;
      r_rd_data <= 8'h00;
    end else if (w_vec_drive) begin
      r_bus_en  <= 1'b1;
      r_bus_ino <= 1'b1;
      r_rd_data <= {r_vec_base, vec_id};
    end else if (w_wr_drive) begin
      r_bus_en  <= 1'b1;
      r_bus_ino <= 1'b0;
      r_rd_data <= 8'h00;
    end else if (w_rd_drive) begin
      r_bus_en  <= 1'b1;
      r_bus_ino <= 1'b1;
      r_rd_data <= r_a0_q ? r_imr : (r_rsel_isr ? isr : irr);
    end else begin
      r_bus_en  <= 1'b0;
      r_bus_ino <= 1'b0;
      r_rd_data <= 8'h00;
    end
  end

  assign rd_data   = r_rd_data;
  assign bus_en    = r_bus_en;
  assign bus_ino   = r_bus_ino;
  assign imr       = r_imr;
  assign vec_base  = r_vec_base;
  assign ltim      = r_ltim;
  assign sngl      = r_sngl;
  assign ic4       = r_ic4;
  assign icw3      = r_icw3;
  assign aeoi      = r_aeoi;
  assign sfnm      = r_sfnm;
  assign ocw2_stb  = r_ocw2_stb;
  assign ocw2_data = r_ocw2_data;
  assign ack1      = r_ack1;
  assign ack2      = r_ack2;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_pic_bus_controller.sv
// Scoreboard bench for pic_bus_controller: directed init/read/INTA/reset cases,
// then randomized bus traffic checked against a queue-based reference model.
module tb_pic_bus_controller;

  localparam logic [1:0] K_READ = 2'd0;
  localparam logic [1:0] K_OCW2 = 2'd1;
  localparam logic [1:0] K_ACK1 = 2'd2;
  localparam logic [1:0] K_ACK2 = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic       inta_n = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic [7:0] irr = 8'h00;
  logic [7:0] isr = 8'h00;
  logic [2:0] vec_id = 3'd0;

  logic [7:0] rd_data;
  logic       bus_en;
  logic       bus_ino;
  logic [7:0] imr;
  logic [4:0] vec_base;
  logic       ltim;
  logic       sngl;
  logic       ic4;
  logic [7:0] icw3;
  logic       aeoi;
  logic       sfnm;
  logic       ocw2_stb;
  logic [7:0] ocw2_data;
  logic       ack1;
  logic       ack2;
  logic       init_done;

  pic_bus_controller dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a0(a0), .inta_n(inta_n), .wdata(wdata), .irr(irr), .isr(isr),
    .vec_id(vec_id), .rd_data(rd_data), .bus_en(bus_en), .bus_ino(bus_ino),
    .imr(imr), .vec_base(vec_base), .ltim(ltim), .sngl(sngl), .ic4(ic4),
    .icw3(icw3), .aeoi(aeoi), .sfnm(sfnm), .ocw2_stb(ocw2_stb),
    .ocw2_data(ocw2_data), .ack1(ack1), .ack2(ack2), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];

  // Reference model: configuration plus the list of ICWs still owed after ICW1.
  bit         m_init;
  int         pending[$];
  logic [7:0] m_imr;
  logic [4:0] m_vecBase;
  logic       m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_rselIsr;
  logic [7:0] m_icw3;
  logic [7:0] m_ocw2;

  function automatic void compare(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void pushExp(logic [1:0] k, logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    expQ.push_back(e);
  endfunction

  function automatic void popCheck(logic [1:0] k, logic [7:0] act, string name);
    exp_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h but no event was expected", name, act);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.data !== act) begin
        bad++;
        $display("[TB] FAIL %s: got kind %0d data 0x%0h expected kind %0d data 0x%0h",
                 name, k, act, e.kind, e.data);
      end
    end
  endfunction

  function automatic void modelReset();
    m_init = 0;
    pending.delete();
    m_imr = 0; m_vecBase = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0;
    m_aeoi = 0; m_sfnm = 0; m_rselIsr = 0; m_icw3 = 0; m_ocw2 = 0;
  endfunction

  function automatic void modelWrite(bit a, logic [7:0] d);
    int step;
    if (!a && d[4]) begin
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_imr = 0; m_icw3 = 0; m_aeoi = 0; m_sfnm = 0; m_rselIsr = 0;
      m_init = 1;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0]) pending.push_back(4);
    end else if (m_init && pending.size() != 0) begin
      if (a) begin
        step = pending.pop_front();
        if (step == 2) m_vecBase = d[7:3];
        else if (step == 3) m_icw3 = d;
        else begin
          m_aeoi = d[1];
          m_sfnm = d[4];
        end
      end
    end else if (m_init) begin
      if (a) m_imr = d;
      else if (!d[3]) begin
        m_ocw2 = d;
        pushExp(K_OCW2, d);
      end else if (d[1]) m_rselIsr = d[0];
    end
  endfunction

  // Monitor: every DUT-presented event is matched against the head of the queue.
  logic prevDrive = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevDrive = 1'b0;
    end else begin
      if (ocw2_stb) popCheck(K_OCW2, ocw2_data, "ocw2_event");
      if (ack1) popCheck(K_ACK1, {7'b0, bus_en}, "ack1_event");
      if (ack2) begin
        popCheck(K_ACK2, rd_data, "ack2_vector");
        compare("ack2_bus", 64'({bus_en, bus_ino}), 64'(2'b11));
      end
      if (bus_en && bus_ino && !prevDrive && !ack2) popCheck(K_READ, rd_data, "read_data");
      prevDrive = bus_en && bus_ino;
    end
  end

  task automatic checkOutput();
    compare("config",
            64'({imr, vec_base, ltim, sngl, ic4, icw3, aeoi, sfnm, init_done}),
            64'({m_imr, m_vecBase, m_ltim, m_sngl, m_ic4, m_icw3, m_aeoi, m_sfnm,
                 (m_init && pending.size() == 0)}));
    compare("ocw2_data", 64'(ocw2_data), 64'(m_ocw2));
    compare("bus_idle", 64'({bus_en, bus_ino}), 64'(0));
  endtask

  task automatic busWrite(bit a, logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; a0 = a; wdata = d; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    compare("write_bus", 64'({bus_en, bus_ino}), 64'(2'b10));
    wr_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b1;
    modelWrite(a, d);
    repeat (3) @(negedge clk);
    checkOutput();
  endtask

  task automatic busRead(bit a, logic [7:0] irrV, logic [7:0] isrV);
    @(negedge clk);
    irr = irrV; isr = isrV;
    cs_n = 1'b0; rd_n = 1'b0; a0 = a;
    pushExp(K_READ, a ? m_imr : (m_rselIsr ? isrV : irrV));
    repeat (4) @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic intaFirst();
    @(negedge clk);
    pushExp(K_ACK1, 8'h00);
    inta_n = 1'b0;
    repeat (3) @(negedge clk);
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic intaSeq(logic [2:0] vid);
    intaFirst();
    vec_id = vid;
    pushExp(K_ACK2, {m_vecBase, vid});
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
    #1;
    compare("reset_outputs",
            64'({rd_data, bus_en, bus_ino, imr, vec_base, ltim, sngl, ic4, icw3,
                 aeoi, sfnm, ocw2_stb, ocw2_data, ack1, ack2, init_done}), 64'(0));
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(int op);
    logic [7:0] r;
    r = 8'($urandom);
    case (op)
      0: busWrite(1'b1, r);
      1: busWrite(1'b0, r & 8'hE7);
      2: busWrite(1'b0, (r & 8'hEF) | 8'h08);
      3: busRead(1'($urandom), 8'($urandom), 8'($urandom));
      4: intaSeq(3'($urandom_range(0, 7)));
      default: busWrite(1'b0, r | 8'h10);
    endcase
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    compare("reset_outputs",
            64'({rd_data, bus_en, bus_ino, imr, vec_base, ltim, sngl, ic4, icw3,
                 aeoi, sfnm, ocw2_stb, ocw2_data, ack1, ack2, init_done}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput();

    busWrite(1'b0, 8'h13);
    busWrite(1'b1, 8'h40);
    busWrite(1'b1, 8'h03);
    compare("plan_icw_a", 64'({init_done, vec_base, aeoi, icw3}), 64'({1'b1, 5'h08, 1'b1, 8'h00}));

    busWrite(1'b0, 8'h10);
    busWrite(1'b1, 8'h20);
    busWrite(1'b1, 8'h04);
    compare("plan_icw_b", 64'({init_done, ic4, icw3}), 64'({1'b1, 1'b0, 8'h04}));

    busWrite(1'b1, 8'hA5);
    busRead(1'b1, 8'h00, 8'h00);
    busWrite(1'b0, 8'h0B);
    busRead(1'b0, 8'h03, 8'h10);
    busWrite(1'b0, 8'h0A);
    busRead(1'b0, 8'h03, 8'h10);
    busWrite(1'b0, 8'h20);

    busWrite(1'b0, 8'h13);
    busWrite(1'b1, 8'h40);
    busWrite(1'b1, 8'h03);
    intaSeq(3'd5);

    busWrite(1'b0, 8'h13);
    doReset();
    busWrite(1'b1, 8'h55);

    busWrite(1'b0, 8'h13);
    busWrite(1'b1, 8'h40);
    busWrite(1'b1, 8'h03);
    intaFirst();
    doReset();
    busWrite(1'b1, 8'h77);
    intaSeq(3'd2);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(int'($urandom_range(0, 6)));
    end

    repeat (10) @(negedge clk);
    compare("queue_drained", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pic_bus_controller.md
# pic_bus_controller

Read/write and interrupt-acknowledge sequencer for the PIC's 8-bit data bus buffer. Samples the CPU strobes (CS_n, RD_n, WR_n, A0, INTA_n), drives the buffer's enable and direction, runs the ICW1–ICW4 initialisation sequence, and holds the OCW1/OCW3 state. It supplies read data (IRR/ISR/IMR/vector) toward the buffer and publishes decoded configuration to the priority and control logic. 8086 mode only.

## Interface
- No parameters.
- clk  in  1  system clock; all inputs are synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- a0  in  1  register address bit
- inta_n  in  1  interrupt acknowledge, active low; independent of cs_n
- wdata  in  8  written byte from the buffer's internal side; bit n = 8259 Dn
- irr, isr  in  8  request/in-service registers from priority logic
- vec_id  in  3  level being acknowledged, valid by the second INTA
- rd_data  out  8  byte presented to the buffer's internal side
- bus_en  out  1  buffer enable
- bus_ino  out  1  buffer direction: 1 = internal→CPU (read), 0 = CPU→internal (write)
- imr  out  8  OCW1 mask
- vec_base  out  5  ICW2[7:3]
- ltim, sngl, ic4  out  1 each  ICW1 bits 3, 1, 0
- icw3  out  8  cascade config
- aeoi, sfnm  out  1 each  ICW4 bits 1, 4
- ocw2_stb  out  1  one-cycle pulse on an OCW2 write
- ocw2_data  out  8  OCW2 byte, valid with ocw2_stb and held afterward
- ack1, ack2  out  1 each  one-cycle pulses for the first and second INTA
- init_done  out  1  initialisation complete

## Operation
- Inputs are registered once (`_q`). A write commits when `wr_q = 0`, `wr_n = 1` and `cs_q = 0` (the WR rising edge). The committed byte and A0 are `wdata_q` and `a0_q`.
- Init FSM states: UNINIT (reset state), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - ICW1 (A0 = 0, D4 = 1) is accepted in any state. It stores ltim/sngl/ic4, clears imr, icw3, aeoi, sfnm and init_done, sets the read select to IRR, and moves to WAIT_ICW2.
  - WAIT_ICW2, A0 = 1: stores vec_base. Goes to WAIT_ICW3 if sngl = 0, else WAIT_ICW4 if ic4 = 1, else READY.
  - WAIT_ICW3, A0 = 1: stores icw3. Goes to WAIT_ICW4 if ic4 = 1, else READY.
  - WAIT_ICW4, A0 = 1: stores aeoi (D1) and sfnm (D4), then goes to READY. D0 = 0 (8080 mode) is stored as nothing and has no effect.
  - init_done = 1 exactly while in READY.
  - Writes with A0 = 0 and D4 = 0 in UNINIT or WAIT_* are ignored. In UNINIT, A0 = 1 writes are also ignored.
- READY state writes:
  - A0 = 1: imr ← byte.
  - A0 = 0, D4 = 0, D3 = 0: OCW2. Pulses ocw2_stb and loads ocw2_data.
  - A0 = 0, D4 = 0, D3 = 1: OCW3. If D1 = 1, read select ← D0 (1 = ISR). If D1 = 0, read select is unchanged.
- Reads (cs_q = 0, rd_q = 0, inta_q = 1):
  - A0 = 1 → rd_data = imr.
  - A0 = 0 → rd_data = isr or irr, per the read select.
  - Reads have no side effects.
- INTA sequencing (sub-FSM IDLE, ACK1, ACK2):
  - First inta_n falling edge: ack1 pulses and the FSM enters ACK1. No bus drive.
  - Second falling edge: ack2 pulses and the FSM enters ACK2. rd_data = {vec_base, vec_id}, with the bus driven while inta_n stays low.
  - inta_n rising edge in ACK2: return to IDLE.
  - INTA overrides a concurrent read. Writes are still processed during INTA.
- Bus control (registered):
  - Read or ACK2 drive: bus_en = 1, bus_ino = 1.
  - Write (cs_q = 0, wr_q = 0): bus_en = 1, bus_ino = 0.
  - Otherwise: bus_en = 0, bus_ino = 0.
  - If rd_n and wr_n are both low, the write wins.

## Timing
- Reset values: every output is 0, the FSM is in UNINIT, and the INTA FSM is in IDLE. Read select is IRR.
- bus_en/bus_ino assert 2 cycles after the strobe falls (input register, then output register). They deassert 2 cycles after it rises.
- Register update and ocw2_stb appear 2 cycles after wr_n rises.
- ack1/ack2 are high for exactly 1 cycle, 2 cycles after the inta_n fall.
- rd_data is registered and valid in the same cycle as bus_en.
- Reset mid-sequence (ICW or INTA) returns to reset values immediately. No partial commit occurs.
- ICW1 during ACK1/ACK2 reinitialises the config but does not disturb the INTA FSM.

## Test plan
- Reset, then ICW1 = 0x13 (A0 = 0), ICW2 = 0x40, ICW4 = 0x03 → states UNINIT → WAIT_ICW2 → WAIT_ICW4 → READY; init_done = 1, vec_base = 0x08, aeoi = 1, icw3 = 0.
- ICW1 = 0x10, ICW2 = 0x20, ICW3 = 0x04 → ic4 = 0 and READY after ICW3; icw3 = 0x04.
- In READY: write A0 = 1 0xA5 → imr = 0xA5. Then read A0 = 1 → rd_data = 0xA5, bus_en = 1, bus_ino = 1.
- OCW3 = 0x0B, then read A0 = 0 with isr = 0x10, irr = 0x03 → rd_data = 0x10. After OCW3 = 0x0A → rd_data = 0x03. OCW2 = 0x20 → ocw2_stb pulses once with ocw2_data = 0x20.
- Two INTA pulses, vec_base = 0x08, vec_id = 5 → ack1 then ack2 pulses; bus not driven on the first pulse; rd_data = 0x45 and bus_en = 1 on the second pulse.
- Assert rst_n low during WAIT_ICW2 and during ACK1 → all outputs 0, UNINIT state; a subsequent A0 = 1 write is ignored and imr stays 0.
